uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Receives one 8N1 UART frame from the serial line and presents the byte with a one-cycle done strobe. It is the receive-side counterpart of the byte transmitter in the UART block and consumes the serial stream that the transmitter produces. It shares the same `baud_set` encoding and the 50 MHz system clock. It uses 16x oversampling with majority-vote sampling and reports framing errors.

## Interface
- `CLK_PERIOD_NS`, default 20: system clock period. Informational only; the divisor constants assume 50 MHz.
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line, asynchronous to `clk`. Idles high.
- `baud_set` input 3: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
- `data` output 8: last correctly framed byte.
- `rx_done` output 1: one-cycle pulse when a good frame has been received.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `uart_state` output 1: high while a frame is being received (from the START state until the return to IDLE).

## Operation
- Reset values:
  - `data`=0x00, `rx_done`=0, `frame_err`=0, `uart_state`=0.
  - Both synchronizer flops=1.
  - State=IDLE, all counters=0.
- `rx` passes through a 2-FF synchronizer, giving `rx_s`. A third flop holds the previous value, `rx_d`, for edge detection.
- `baud_set` is latched into `baud_q` on the start-edge cycle. Changes to `baud_set` mid-frame have no effect.
- The tick generator runs only while `uart_state`=1 and starts from 0 at the start edge. It pulses `tick` when its counter equals the reload value, then wraps to 0.
- Reload values (cycles-1) per `baud_q`: 324, 161, 80, 53, 26. Each tick counter is 9 bits.
- Within each bit, a 4-bit `smp_cnt` counts ticks 0..15. Bit samples are taken at `smp_cnt` 7, 8 and 9, and the majority of the three is the bit value.
- States:
  - IDLE: on `rx_d`=1 and `rx_s`=0, go to START and set `uart_state`=1.
  - START:
    - Majority at tick 9: if 1 (glitch), go to IDLE and clear `uart_state`; no pulse is generated.
    - Otherwise, at tick 15, go to DATA with `bit_cnt`=0.
  - DATA: the majority bit is shifted in LSB first. At tick 15 of `bit_cnt`=7, go to STOP; otherwise increment `bit_cnt`.
  - STOP: evaluated at tick 9 (majority decided).
    - Majority 1: load `data` from the shift register and pulse `rx_done`.
    - Majority 0: pulse `frame_err`; `data` keeps its old value.
    - Either way, go to IDLE and clear `uart_state` in the same cycle, leaving half a bit of margin for resynchronisation.
- After a frame error, a new frame requires a fresh high-to-low edge. A continuous low (break) produces no further frames.
- `rx_done` and `frame_err` are never high together.
- Asserting `rst` mid-frame aborts the frame immediately. No pulse is generated and all outputs take their reset values.

## Timing
- Start-edge latency is 3 `clk` cycles from the `rx` pin falling edge to the START state.
- The `rx_done` or `frame_err` pulse is registered and appears on the cycle after the stop-bit tick-9 evaluation.
- `data` is valid in the same cycle that `rx_done`=1 and holds until the next good frame.
- Nominal frame length to the pulse is (16·9+10)·(reload+1) cycles. At 115200 this is 154·27=4158 cycles after the start edge.
- Back-to-back frames with zero idle are accepted. IDLE is re-entered 6 ticks before the stop bit ends, so the next falling edge is caught.
- Baud tolerance is ±3% cumulative over the frame.

## Structure
- Package `uart_pkg` holds:
  - the baud reload constants, indexed by the `baud_set` encoding;
  - the `baud_set` enum, shared with the transmitter;
  - the `rx_state_t` enum (IDLE, START, DATA, STOP).
- Sub-module `uart_rx_tick_gen` takes `clk`, `rst`, `en` and `reload[8:0]`, and outputs `tick`.
- The synchronizer, FSM, shift register and majority logic live in the top module.

## Test plan
- Send 0x55 at 115200 with an ideal bit time of 434 cycles → exactly one `rx_done` with `data`=0x55, `frame_err` stays 0, and `uart_state` falls on the pulse cycle.
- Drive a 150-cycle low glitch on an idle line at 9600 → no `rx_done`, no `frame_err`, `uart_state` returns to 0, `data` unchanged.
- Send 0xA3 with the stop bit driven low at 38400 → one `frame_err` pulse, no `rx_done`, `data` keeps the previous 0x55.
- Send 0x00 then 0xFF back-to-back with no idle at 57600 → two `rx_done` pulses with `data` 0x00 then 0xFF.
- Send 0x3C at 19200 with the bit period stretched by +2.5% and `baud_set` toggled to 4 mid-frame → `data`=0x3C and `rx_done` asserted.
- Assert `rst` for 2 cycles during bit 4 of a frame → outputs go to their reset values and no pulse occurs. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud encoding, receiver states and the 16x tick reload table.
package uart_pkg;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_set_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // Tick reload values (cycles-1) for a 16x oversample clock at 50 MHz.
  localparam logic [8:0] RELOAD_9600   = 9'd324;
  localparam logic [8:0] RELOAD_19200  = 9'd161;
  localparam logic [8:0] RELOAD_38400  = 9'd80;
  localparam logic [8:0] RELOAD_57600  = 9'd53;
  localparam logic [8:0] RELOAD_115200 = 9'd26;

  localparam logic [3:0] SMP_FIRST  = 4'd7;
  localparam logic [3:0] SMP_MID    = 4'd8;
  localparam logic [3:0] SMP_DECIDE = 4'd9;
  localparam logic [3:0] SMP_LAST   = 4'd15;
  localparam logic [2:0] BIT_LAST   = 3'd7;

  function automatic logic [8:0] baud_reload(input logic [2:0] sel);
    case (baud_set_t'(sel))
      BAUD_19200:  baud_reload = RELOAD_19200;
      BAUD_38400:  baud_reload = RELOAD_38400;
      BAUD_57600:  baud_reload = RELOAD_57600;
      BAUD_115200: baud_reload = RELOAD_115200;
      default:     baud_reload = RELOAD_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick generator; held at zero while disabled so every frame starts phase-aligned.
module uart_rx_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [8:0] reload,
  output logic       tick
);

  logic [8:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 9'd0;
    end else if (!en || cnt == reload) begin
      cnt <= 9'd0;
    end else begin
      cnt <= cnt + 9'd1;
    end
  end

  assign tick = en && (cnt == reload);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling, 3-sample majority vote and framing-error report.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  logic       rx_m, rx_s, rx_d;
  rx_state_t  state;
  logic [2:0] baud_q;
  logic [3:0] smp_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       s7, s8;
  logic       tick, maj;
  logic [8:0] reload;
  logic       unused_period;

  // The period is informational; the reload table already assumes 50 MHz.
  assign unused_period = ^CLK_PERIOD_NS;

  assign reload = baud_reload(baud_q);
  assign maj    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  uart_rx_tick_gen u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (uart_state),
    .reload (reload),
    .tick   (tick)
  );

  // Reset high so an idle line never looks like a start edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      uart_state <= 1'b0;
      baud_q     <= 3'd0;
      smp_cnt    <= 4'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      s7         <= 1'b0;
      s8         <= 1'b0;
      data       <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        smp_cnt <= smp_cnt + 4'd1;
        if (smp_cnt == SMP_FIRST) s7 <= rx_s;
        if (smp_cnt == SMP_MID)   s8 <= rx_s;
      end
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state      <= START;
            uart_state <= 1'b1;
            baud_q     <= baud_set;
            smp_cnt    <= 4'd0;
            bit_cnt    <= 3'd0;
          end
        end
        START: begin
          if (tick && smp_cnt == SMP_DECIDE && maj) begin
            state      <= IDLE;
            uart_state <= 1'b0;
          end else if (tick && smp_cnt == SMP_LAST) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (tick && smp_cnt == SMP_DECIDE) shift <= {maj, shift[7:1]};
          if (tick && smp_cnt == SMP_LAST) begin
            if (bit_cnt == BIT_LAST) state <= STOP;
            else                     bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is still caught.
          if (tick && smp_cnt == SMP_DECIDE) begin
            state      <= IDLE;
            uart_state <= 1'b0;
            if (maj) begin
              data    <= shift;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed, table-driven bench for uart_byte_rx with hand-written corner-case sequences.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [2:0] baud_set;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0;
  int fall_cyc = 0, start_cyc = 0, pulse_cyc = 0;
  logic state_at_pulse = 1'b1;
  logic prev_state = 1'b0;
  logic both_seen = 1'b0;
  int data_q[$];

  typedef struct {
    logic [2:0] baud;
    bit         toggle;
    int         bit_cycles;
    logic [7:0] byte_val;
    logic       stop_val;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[3];

  uart_byte_rx #(.CLK_PERIOD_NS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_set   (baud_set),
    .data       (data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (uart_state && !prev_state) start_cyc = cyc;
    prev_state = uart_state;
    if (rx_done) begin
      done_cnt++;
      data_q.push_back(int'(data));
      pulse_cyc = cyc;
      state_at_pulse = uart_state;
    end
    if (frame_err) begin
      err_cnt++;
      pulse_cyc = cyc;
      state_at_pulse = uart_state;
    end
    if (rx_done && frame_err) both_seen = 1'b1;
  end

  // Oversample period per baud encoding, in clk cycles.
  function automatic int tick_cycles(input logic [2:0] b);
    case (b)
      3'd1:    tick_cycles = 162;
      3'd2:    tick_cycles = 81;
      3'd3:    tick_cycles = 54;
      3'd4:    tick_cycles = 27;
      default: tick_cycles = 325;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; expects to be called just after a rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int bit_cycles, input logic stop_val);
    logic [9:0] frame;
    frame = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      if (i == 0) fall_cyc = cyc;
      repeat (bit_cycles) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    int done0, err0, s0;

    rst = 1'b1;
    rx = 1'b1;
    baud_set = 3'd0;
    idle_cycles(3);
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_rx_done", int'(rx_done), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_uart_state", int'(uart_state), 0);
    rst = 1'b0;
    idle_cycles(20);

    vecs[0] = '{3'd4, 1'b0, 434, 8'h55, 1'b1, 8'h55, 1, 0};
    vecs[1] = '{3'd2, 1'b0, 1302, 8'hA3, 1'b0, 8'h55, 0, 1};
    vecs[2] = '{3'd1, 1'b1, 2669, 8'h3C, 1'b1, 8'h3C, 1, 0};

    for (int i = 0; i < 3; i++) begin
      baud_set = vecs[i].baud;
      done0 = done_cnt;
      err0  = err_cnt;
      fork
        applyStimulus(vecs[i].byte_val, vecs[i].bit_cycles, vecs[i].stop_val);
        begin
          if (vecs[i].toggle) begin
            repeat (3 * vecs[i].bit_cycles) @(posedge clk);
            #1;
            baud_set = 3'd4;
          end
        end
      join
      idle_cycles(50);
      checkOutput($sformatf("vec%0d_done_count", i), done_cnt - done0, vecs[i].exp_done);
      checkOutput($sformatf("vec%0d_err_count", i), err_cnt - err0, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_start_latency", i), start_cyc - fall_cyc, 3);
      checkOutput($sformatf("vec%0d_pulse_time", i), pulse_cyc - start_cyc,
                  154 * tick_cycles(vecs[i].baud));
      checkOutput($sformatf("vec%0d_state_at_pulse", i), int'(state_at_pulse), 0);
    end

    $display("[TB] glitch on idle line at 9600");
    baud_set = 3'd0;
    done0 = done_cnt;
    err0  = err_cnt;
    s0    = start_cyc;
    rx = 1'b0;
    idle_cycles(150);
    rx = 1'b1;
    idle_cycles(4000);
    checkOutput("glitch_start_seen", int'(start_cyc != s0), 1);
    checkOutput("glitch_uart_state", int'(uart_state), 0);
    checkOutput("glitch_done_count", done_cnt - done0, 0);
    checkOutput("glitch_err_count", err_cnt - err0, 0);
    checkOutput("glitch_data", int'(data), 8'h3C);

    $display("[TB] back-to-back frames at 57600");
    baud_set = 3'd3;
    done0 = done_cnt;
    err0  = err_cnt;
    data_q.delete();
    applyStimulus(8'h00, 868, 1'b1);
    applyStimulus(8'hFF, 868, 1'b1);
    idle_cycles(50);
    checkOutput("b2b_done_count", done_cnt - done0, 2);
    checkOutput("b2b_err_count", err_cnt - err0, 0);
    checkOutput("b2b_first", (data_q.size() > 0) ? data_q[0] : -1, 8'h00);
    checkOutput("b2b_second", (data_q.size() > 1) ? data_q[1] : -1, 8'hFF);

    $display("[TB] reset during data bit 4");
    baud_set = 3'd4;
    done0 = done_cnt;
    err0  = err_cnt;
    fork
      applyStimulus(8'hF0, 434, 1'b1);
      begin
        repeat (2300) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", int'(uart_state), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_data", int'(data), 0);
        checkOutput("midrst_uart_state", int'(uart_state), 0);
        checkOutput("midrst_rx_done", int'(rx_done), 0);
        checkOutput("midrst_frame_err", int'(frame_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    idle_cycles(100);
    checkOutput("postrst_done_count", done_cnt - done0, 0);
    checkOutput("postrst_err_count", err_cnt - err0, 0);
    checkOutput("postrst_uart_state", int'(uart_state), 0);

    done0 = done_cnt;
    applyStimulus(8'h81, 434, 1'b1);
    idle_cycles(50);
    checkOutput("recover_done_count", done_cnt - done0, 1);
    checkOutput("recover_data", int'(data), 8'h81);

    checkOutput("never_both_pulses", int'(both_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
